// File: rtl/lab2_dg_display_scan.sv
// Scans NUM_DIGITS common-anode digits through one shared seven-segment decoder.
// Each digit step is a blanking interval (all anodes off), then a refresh interval.
module lab2_dg_display_scan #(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  output logic [3:0]                    mux_out,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [3:0]            mux_reg, mux_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  frame_reg, frame_next;

  logic [3:0]            nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_sel;

  // Per-digit nibble view and one-hot decode of the selected digit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi] = digits_in[4*gi +: 4];
      assign an_sel[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      mux_reg   <= '0;
      an_reg    <= '1;
      frame_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      mux_reg   <= mux_next;
      an_reg    <= an_next;
      frame_reg <= frame_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    mux_next   = mux_reg;
    an_next    = an_reg;
    frame_next = 1'b0;

    if (!enable) begin
      // Pausing restarts the current digit's step; index and nibble are kept.
      state_next = ST_BLANK;
      cnt_next   = '0;
      an_next    = '1;
    end else begin
      case (state_reg)
        ST_BLANK: begin
          an_next  = '1;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == '0) begin
            mux_next = nibble[idx_reg];
          end
          if (cnt_reg == CW'(BLANK_CYCLES - 1)) begin
            state_next = ST_DRIVE;
            cnt_next   = '0;
            an_next    = ~an_sel;
          end
        end
        ST_DRIVE: begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CW'(REFRESH_CYCLES - 1)) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            an_next    = '1;
            if (idx_reg == IW'(NUM_DIGITS - 1)) begin
              idx_next   = '0;
              frame_next = 1'b1;
            end else begin
              idx_next = idx_reg + IW'(1);
            end
          end
        end
        default: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          an_next    = '1;
        end
      endcase
    end
  end

  assign mux_out    = mux_reg;
  assign an_n       = an_reg;
  assign digit_idx  = idx_reg;
  assign frame_done = frame_reg;

endmodule
